// File: rtl/half_add.sv
// Half adder: the two-input building block used twice inside full_add.
// Sum is the XOR of the operands and carry-out is their AND.
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    assign s  = a ^ b;
    assign co = a & b;

endmodule

// File: rtl/full_add.sv
// Single-bit full adder with an optional registered copy of {carry, sum}.
// This is the basic cell for ripple-carry adders: carry of bit i drives c of bit i+1.
module full_add (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic en,
    output logic sum,
    output logic carry,
    output logic sum_q,
    output logic carry_q
);

    logic s1;
    logic c1;
    logic c2;

    half_add u_ha_ab (
        .a  (a),
        .b  (b),
        .s  (s1),
        .co (c1)
    );

    half_add u_ha_sc (
        .a  (s1),
        .b  (c),
        .s  (sum),
        .co (c2)
    );

    // Only one of the two half adders can produce a carry at a time.
    assign carry = c1 | c2;

    // Reset takes priority over enable; without enable the registers hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (en) begin
            sum_q   <= sum;
            carry_q <= carry;
        end
    end

endmodule

// File: tb/tb_full_add.sv
// Self-checking bench for full_add: combinational sweep, directed register
// scenarios and a randomized run against an arithmetic reference model.
module tb_full_add;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic en;
    logic sum;
    logic carry;
    logic sum_q;
    logic carry_q;

    bit   clk_run;
    int   test_count;
    int   fail_count;
    logic [1:0] exp_q;

    full_add dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .en      (en),
        .sum     (sum),
        .carry   (carry),
        .sum_q   (sum_q),
        .carry_q (carry_q)
    );

    // Clock stays parked low until the combinational sweep is done.
    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [1:0] observed,
                               input logic [1:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Drive one input vector, check the combinational result, clock it and
    // check the registered result against the reference model.
    task automatic applyStimulus(input logic ia, input logic ib, input logic ic,
                                 input logic ien, input logic irst, input string tag);
        logic [1:0] exp_sum;
        a   = ia;
        b   = ib;
        c   = ic;
        en  = ien;
        rst = irst;
        exp_sum = 2'(ia) + 2'(ib) + 2'(ic);
        #1;
        checkOutput({tag, "_comb"}, {carry, sum}, exp_sum);
        if (irst)
            exp_q = 2'b00;
        else if (ien)
            exp_q = exp_sum;
        @(posedge clk);
        #1;
        checkOutput({tag, "_reg"}, {carry_q, sum_q}, exp_q);
    endtask

    logic [1:0] truth [8];
    logic [2:0] vec;

    initial begin
        test_count = 0;
        fail_count = 0;
        clk_run    = 1'b0;
        rst = 1'b0;
        en  = 1'b0;
        a   = 1'b0;
        b   = 1'b0;
        c   = 1'b0;
        truth = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Exhaustive combinational sweep with no clock running.
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {a, b, c} = vec;
            #10;
            checkOutput($sformatf("sweep_%0d", i), {carry, sum}, truth[i]);
        end
        #100;

        clk_run = 1'b1;

        // Reset for two cycles with enable high.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "reset0");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset1");

        // Capture 111 one cycle after release.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "capture111");

        // Enable hold: capture 100, then hold while inputs change to 111.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "capture100");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "hold0");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "hold1");

        // Reset wins over enable.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rst_prio");

        // Random traffic with a one-cycle reset pulse in the middle.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, "pre_pulse");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "pulse");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, "post_pulse");

        // Randomized run against the reference model, enable toggling freely.
        for (int i = 0; i < 1000; i++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'b0, "random");

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
